// File: rtl/sumador_serial.sv
// Multi-cycle adder/subtractor with accumulator: DIGIT bits per clock, LSB first,
// operands and results exchanged through valid/ready handshakes.
module sumador_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_acc;
    logic [1:0]       r_mode;
    logic             r_cin;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;
    logic [DIGIT-1:0] w_ds;
    logic             w_cout;
    logic             w_last;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_ds_ext;
    logic [WIDTH-1:0] w_res_nxt;

    // Operands shift right each cycle, so the active digit is always the low one;
    // result digits enter at the top and settle into place after NDIG shifts.
    always_comb begin
        w_da              = r_a[DIGIT-1:0];
        w_db              = r_b[DIGIT-1:0];
        {w_cout, w_ds}    = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT{1'b0}}, r_cin};
        w_c_msb           = w_da[DIGIT-1] ^ w_db[DIGIT-1] ^ w_ds[DIGIT-1];
        w_ds_ext          = '0;
        w_ds_ext[DIGIT-1:0] = w_ds;
        w_res_nxt         = (r_res >> DIGIT) | (w_ds_ext << (WIDTH - DIGIT));
        w_last            = (r_cnt == CW'(NDIG - 1));
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_state_nxt = (mode == 2'b11) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (w_last)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_acc    <= '0;
            r_mode   <= '0;
            r_cin    <= 1'b0;
            r_cnt    <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a    <= op_a;
                        r_mode <= mode;
                        r_cnt  <= '0;
                        r_res  <= '0;
                        r_cin  <= (mode == 2'b01);
                        case (mode)
                            2'b00:   r_b <= op_b;
                            2'b01:   r_b <= ~op_b;
                            2'b10:   r_b <= r_acc;
                            default: r_b <= '0;
                        endcase
                        if (mode == 2'b11) begin
                            r_acc    <= '0;
                            sum      <= '0;
                            carry    <= 1'b0;
                            overflow <= 1'b0;
                            zero     <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_a   <= r_a >> DIGIT;
                    r_b   <= r_b >> DIGIT;
                    r_res <= w_res_nxt;
                    r_cin <= w_cout;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        sum      <= w_res_nxt;
                        carry    <= w_cout;
                        overflow <= w_c_msb ^ w_cout;
                        zero     <= (w_res_nxt == '0);
                        if (r_mode == 2'b10)
                            r_acc <= w_res_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sumador_serial.sv
// Self-checking bench for sumador_serial: three 8-bit instances (DIGIT 1, 2, 8)
// driven in lockstep plus a 16-bit/DIGIT-4 instance, all against an arithmetic model.
module tb_sumador_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, out_ready;
    logic [7:0] op_a, op_b;
    logic [1:0] mode;
    logic [2:0] in_ready_v, out_valid_v, carry_v, ovf_v, zero_v, busy_v;
    logic [7:0] sum_v [3];

    logic        in_valid16, out_ready16;
    logic [15:0] op_a16, op_b16, sum16;
    logic [1:0]  mode16;
    logic        in_ready16, out_valid16, carry16, ovf16, zero16, busy16;

    int checks   = 0;
    int failures = 0;
    logic [63:0] acc8  = '0;
    logic [63:0] acc16 = '0;

    always #5 clk = ~clk;

    sumador_serial #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .op_a(op_a), .op_b(op_b), .mode(mode), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .sum(sum_v[0]), .carry(carry_v[0]),
        .overflow(ovf_v[0]), .zero(zero_v[0]), .busy(busy_v[0]));

    sumador_serial #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .op_a(op_a), .op_b(op_b), .mode(mode), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .sum(sum_v[1]), .carry(carry_v[1]),
        .overflow(ovf_v[1]), .zero(zero_v[1]), .busy(busy_v[1]));

    sumador_serial #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .op_a(op_a), .op_b(op_b), .mode(mode), .out_valid(out_valid_v[2]),
        .out_ready(out_ready), .sum(sum_v[2]), .carry(carry_v[2]),
        .overflow(ovf_v[2]), .zero(zero_v[2]), .busy(busy_v[2]));

    sumador_serial #(.WIDTH(16), .DIGIT(4)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .op_a(op_a16), .op_b(op_b16), .mode(mode16), .out_valid(out_valid16),
        .out_ready(out_ready16), .sum(sum16), .carry(carry16),
        .overflow(ovf16), .zero(zero16), .busy(busy16));

    function automatic int dig(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 8);
    endfunction

    // Plain integer arithmetic: unsigned for sum/carry, signed range test for overflow.
    function automatic void model(input int w, input logic [1:0] m,
                                  input logic [63:0] a, input logic [63:0] b,
                                  inout logic [63:0] acc, output logic [63:0] s,
                                  output logic c, output logic o, output logic z);
        longint unsigned mask, ua, ub, ur;
        longint sa, sb, sr, smax, smin;
        mask = (64'd1 << w) - 1;
        smax = (64'sd1 <<< (w - 1)) - 1;
        smin = -(64'sd1 <<< (w - 1));
        if (m == 2'b11) begin
            s = '0; c = 1'b0; o = 1'b0; acc = '0;
        end else begin
            ua = a & mask;
            ub = (m == 2'b10) ? (acc & mask) : (b & mask);
            sa = longint'(ua); sb = longint'(ub);
            if (ua[w-1]) sa = sa - (64'sd1 <<< w);
            if (ub[w-1]) sb = sb - (64'sd1 <<< w);
            if (m == 2'b01) begin
                ur = ua - ub; c = (ua >= ub); sr = sa - sb;
            end else begin
                ur = ua + ub; c = ((ur >> w) & 1) != 0; sr = sa + sb;
            end
            s = ur & mask;
            o = (sr > smax) || (sr < smin);
            if (m == 2'b10) acc = s;
        end
        z = (s == 0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do8(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                       input int hold);
        logic [63:0] es;
        logic ec, eo, ez;
        int lat [3];
        bit all;
        model(8, m, {56'd0, a}, {56'd0, b}, acc8, es, ec, eo, ez);
        in_valid = 1'b1; op_a = a; op_b = b; mode = m;
        tick();
        in_valid = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom); mode = 2'($urandom);
        for (int i = 0; i < 3; i++) lat[i] = 0;
        for (int n = 1; n <= 40; n++) begin
            all = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (lat[i] == 0 && out_valid_v[i]) lat[i] = n;
                if (lat[i] == 0) all = 1'b0;
            end
            if (all) break;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("latency[%0d]", i), lat[i], (m == 2'b11) ? 1 : 8 / dig(i) + 1);
            chk($sformatf("sum[%0d]", i), sum_v[i], es);
            chk($sformatf("carry[%0d]", i), carry_v[i], ec);
            chk($sformatf("overflow[%0d]", i), ovf_v[i], eo);
            chk($sformatf("zero[%0d]", i), zero_v[i], ez);
            chk($sformatf("in_ready_done[%0d]", i), in_ready_v[i], 0);
            chk($sformatf("busy_done[%0d]", i), busy_v[i], 1);
        end
        repeat (hold) begin
            in_valid = 1'b1; op_a = 8'($urandom); op_b = 8'($urandom); mode = 2'($urandom);
            tick();
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("hold_valid[%0d]", i), out_valid_v[i], 1);
                chk($sformatf("hold_in_ready[%0d]", i), in_ready_v[i], 0);
                chk($sformatf("hold_sum[%0d]", i), sum_v[i], es);
                chk($sformatf("hold_carry[%0d]", i), carry_v[i], ec);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("idle_valid[%0d]", i), out_valid_v[i], 0);
            chk($sformatf("idle_in_ready[%0d]", i), in_ready_v[i], 1);
            chk($sformatf("idle_sum_held[%0d]", i), sum_v[i], es);
        end
    endtask

    task automatic do16(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
        logic [63:0] es;
        logic ec, eo, ez;
        int lat;
        model(16, m, {48'd0, a}, {48'd0, b}, acc16, es, ec, eo, ez);
        in_valid16 = 1'b1; op_a16 = a; op_b16 = b; mode16 = m;
        tick();
        in_valid16 = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (out_valid16) begin
                lat = n;
                break;
            end
            tick();
        end
        chk("w16_latency", lat, (m == 2'b11) ? 1 : 5);
        chk("w16_sum", sum16, es);
        chk("w16_carry", carry16, ec);
        chk("w16_overflow", ovf16, eo);
        chk("w16_zero", zero16, ez);
        out_ready16 = 1'b1;
        tick();
        out_ready16 = 1'b0;
        chk("w16_in_ready", in_ready16, 1);
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_in_ready[%0d]", tag, i), in_ready_v[i], 1);
            chk($sformatf("%s_valid[%0d]", tag, i), out_valid_v[i], 0);
            chk($sformatf("%s_busy[%0d]", tag, i), busy_v[i], 0);
            chk($sformatf("%s_sum[%0d]", tag, i), sum_v[i], 0);
            chk($sformatf("%s_flags[%0d]", tag, i),
                {carry_v[i], ovf_v[i], zero_v[i]}, 3'b000);
        end
    endtask

    initial begin
        logic [1:0] rm;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; mode = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; op_a16 = '0; op_b16 = '0; mode16 = '0;
        repeat (2) tick();
        check_reset("reset");
        chk("w16_reset_in_ready", in_ready16, 1);
        chk("w16_reset_sum", sum16, 0);
        rst = 1'b0;
        tick();

        do8(2'b00, 8'd200, 8'd100, 0);
        do8(2'b00, 8'd100, 8'd100, 0);
        do8(2'b01, 8'd5, 8'd7, 0);
        do8(2'b01, 8'h80, 8'h01, 0);
        do8(2'b11, 8'h00, 8'h00, 0);
        repeat (3) do8(2'b10, 8'h10, 8'h5A, 0);
        do8(2'b10, 8'hE0, 8'h00, 0);
        do8(2'b11, 8'h33, 8'h44, 0);

        // Backpressure, then an operand offered right after the handshake.
        do8(2'b00, 8'h12, 8'h34, 5);
        do8(2'b01, 8'h34, 8'h12, 0);

        // Reset four cycles into a computation.
        do8(2'b10, 8'h44, 8'h00, 0);
        in_valid = 1'b1; op_a = 8'h0F; op_b = 8'h01; mode = 2'b00;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc8 = '0;
        check_reset("rst_calc");

        // Reset while a result waits in DONE.
        in_valid = 1'b1; op_a = 8'h55; op_b = 8'h00; mode = 2'b10;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 40 && out_valid_v != 3'b111; n++) tick();
        chk("wait_done_before_reset", out_valid_v, 3'b111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc8 = '0;
        check_reset("rst_done");
        do8(2'b00, 8'd3, 8'd4, 0);
        do8(2'b10, 8'h21, 8'h00, 0);

        for (int t = 0; t < 40; t++) begin
            rm = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            do8(rm, 8'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0) ? 2 : 0);
        end

        do16(2'b00, 16'hFFFF, 16'h0001);
        for (int t = 0; t < 25; t++) begin
            rm = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            do16(rm, 16'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sumador_serial.md
Name: sumador_serial

Overview:
Parametrised multi-cycle adder/subtractor with accumulator, the successor to the fixed 8-bit combinational adder. It processes DIGIT bits per clock from LSB to MSB through a single DIGIT-wide carry chain. Operands enter and results leave through valid/ready handshakes. The accumulate mode keeps a running sum across transactions. It sits behind the tile I/O wrapper and is area-scalable through WIDTH and DIGIT.

Parameters:
WIDTH, 8, operand/result width in bits (>=2).
DIGIT, 1, bits processed per cycle; must divide WIDTH exactly (1 = bit-serial, WIDTH = single-cycle compute).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand transaction offered
in_ready  output  1  block can accept operands
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B (ignored in modes 10, 11)
mode  input  2  00 add A+B; 01 sub A-B; 10 acc: acc+A; 11 clear acc
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
carry  output  1  carry-out of MSB (for sub: 1 = no borrow)
overflow  output  1  two's-complement signed overflow
zero  output  1  sum == 0
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE, acc=0, sum=0, carry=0, overflow=0, zero=0, out_valid=0, in_ready=1, busy=0. Reset overrides everything, including mid-CALC and DONE; any in-flight result is discarded.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - Latch op_a and mode.
  - Latch operand B as op_b (mode 00), ~op_b (mode 01) or acc (mode 10).
  - Carry-in is 1 for mode 01, else 0.
  - Digit counter resets to 0.
  - Mode 11 goes to DONE; all other modes go to CALC.
- CALC:
  - Each cycle, add digit k of A, digit k of B and the registered carry.
  - Write the result digit into the shift/result register and register carry-out.
  - k increments each cycle. After digit WIDTH/DIGIT-1 the FSM goes to DONE.
  - CALC lasts exactly WIDTH/DIGIT cycles.
- Latency: out_valid asserts WIDTH/DIGIT+1 clocks after the accepting edge (mode 11: 1 clock).
- DONE: out_valid=1. sum/carry/overflow/zero are stable and held until out_ready=1 at an edge, then the FSM returns to IDLE.
  - No new operand is accepted while in CALC or DONE: in_ready=0. Operands are never dropped; the producer holds them.
  - in_valid during DONE is ignored until the FSM is back in IDLE (the earliest accept is the cycle after out_ready handshake).
- Result flags:
  - carry = final carry-out of bit WIDTH-1.
  - overflow = carry into MSB XOR carry out of MSB (equivalently, operand sign bits equal and result sign differs, using the effective B).
  - zero = (sum==0).
- Mode 10: on entering DONE, acc <= sum. Accumulator width is WIDTH and wraps modulo 2^WIDTH; carry and overflow report the wrap.
- Mode 11: acc <= 0 on entering DONE; sum=0, carry=0, overflow=0, zero=1.
- Modes 00/01 do not modify acc.
- sum holds its last value while in IDLE (not cleared after a handshake). Flags likewise.
- Back-to-back: with in_valid and out_ready both held high, throughput is one result per WIDTH/DIGIT+2 cycles (mode 11: 2 cycles).

Test Plan:
- Reset, then WIDTH=8, DIGIT=1, add 200+100 -> after 9 clocks out_valid=1, sum=44, carry=1, overflow=0, zero=0.
- add 100+100 -> sum=200, carry=0, overflow=1; sub 5-7 -> sum=254, carry=0, overflow=0; sub 0x80-0x01 -> sum=0x7F, carry=1, overflow=1.
- clear, then acc 0x10 three times -> sums 0x10, 0x20, 0x30. Then acc 0xE0 -> sum=0x10, carry=1. Then clear -> sum=0, zero=1 after 1 clock.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE, and the next operand is accepted the following cycle.
- Reset asserted mid-CALC (cycle 4 of 8) and mid-DONE -> next edge: IDLE, out_valid=0, acc=0, in_ready=1; a subsequent add 3+4 -> sum=7.
- Parametric: WIDTH=16, DIGIT=4, add 0xFFFF+0x0001 -> out_valid after 5 clocks, sum=0, carry=1, zero=1, overflow=0. Random add/sub/acc sweep checked against a reference model for DIGIT=1, 2, WIDTH.
